data_memory_hs: RTL

Parametrised, handshaked successor to the core's data memory for the MEM stage.
- Accepts one load/store request at a time over a valid/ready interface.
- Performs byte-lane-masked word storage.
- Returns a response after a configurable latency, with sign/zero-extended load data and a fault code (misaligned, out-of-range, illegal funct3).
- Lets the pipeline stall on memory and is the stepping stone to a cache/bus port.

---
 rtl/data_memory_hs.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/data_memory_hs.sv
// Handshaked MEM-stage data memory: one outstanding load/store, byte-lane masked
// word storage, and a registered response after a fixed latency with a fault code.
module data_memory_hs #(
   parameter int DATA_WIDTH         = 64,
   parameter int ADDR_BITS          = 10,
   parameter int READ_LATENCY       = 1,
   parameter     DATA_MEM_INIT_FILE = ""
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_we_i,
   input  logic [DATA_WIDTH-1:0] req_addr_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   input  logic [2:0]            req_funct3_i,
   output logic                  resp_valid_o,
   input  logic                  resp_ready_i,
   output logic [DATA_WIDTH-1:0] resp_rdata_o,
   output logic [1:0]            resp_fault_o
);

   localparam int BYTES     = DATA_WIDTH / 8;
   localparam int OFF_BITS  = $clog2(BYTES);
   localparam int WORDS     = (2 ** ADDR_BITS) / BYTES;
   localparam int WIDX_BITS = ADDR_BITS - OFF_BITS;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_e;

   typedef enum logic [1:0] {
      FAULT_NONE     = 2'd0,
      FAULT_MISALIGN = 2'd1,
      FAULT_RANGE    = 2'd2,
      FAULT_ILLEGAL  = 2'd3
   } fault_e;

   // funct3[1:0] encodes the access size, funct3[2] selects zero extension on loads
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   logic [DATA_WIDTH-1:0] mem [WORDS];

   state_e                state;
   logic [2:0]            cnt;

   logic                  accept;
   logic [1:0]            size;
   logic [WIDX_BITS-1:0]  widx;
   logic [OFF_BITS-1:0]   off;
   logic [OFF_BITS+2:0]   bit_shift;
   logic                  illegal;
   logic                  misaligned;
   logic                  out_of_range;
   fault_e                fault;
   logic [BYTES-1:0]      lane_base;
   logic [BYTES-1:0]      wmask;
   logic [DATA_WIDTH-1:0] wdata_sh;
   logic [DATA_WIDTH-1:0] rd_sh;
   logic [DATA_WIDTH-1:0] load_data;

   // Load-time image: storage starts all zero.
   initial begin
      for (int w = 0; w < WORDS; w++) mem[w] = '0;
   end

   assign accept    = req_ready_o && req_valid_i;
   assign size      = req_funct3_i[1:0];
   assign widx      = req_addr_i[ADDR_BITS-1:OFF_BITS];
   assign off       = req_addr_i[OFF_BITS-1:0];
   assign bit_shift = {off, 3'b000};

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no latch can be inferred.
      illegal      = 1'b0;
      misaligned   = 1'b0;
      out_of_range = |(req_addr_i >> ADDR_BITS);
      fault        = FAULT_NONE;

      if (req_we_i) begin
         illegal = req_funct3_i[2] || (size == 2'd3 && DATA_WIDTH == 32);
      end else begin
         illegal = (req_funct3_i == 3'b111) ||
                   (DATA_WIDTH == 32 && (req_funct3_i == F3_D || req_funct3_i == F3_WU));
      end

      case (size)
         2'd1:    misaligned = req_addr_i[0];
         2'd2:    misaligned = |req_addr_i[1:0];
         2'd3:    misaligned = |req_addr_i[2:0];
         default: misaligned = 1'b0;
      endcase

      if (illegal)           fault = FAULT_ILLEGAL;
      else if (misaligned)   fault = FAULT_MISALIGN;
      else if (out_of_range) fault = FAULT_RANGE;
      else                   fault = FAULT_NONE;
   end

   always_comb begin
      lane_base = '1;
      case (size)
         2'd0:    lane_base = BYTES'(1);
         2'd1:    lane_base = BYTES'(3);
         2'd2:    lane_base = BYTES'(15);
         default: lane_base = '1;
      endcase
   end

   assign wmask    = lane_base << off;
   assign wdata_sh = req_wdata_i << bit_shift;

   // Lane select first, then extend from the bottom of the shifted word.
   assign rd_sh = mem[widx] >> bit_shift;

   always_comb begin
      load_data = '0;
      case (req_funct3_i)
         F3_B:    load_data = DATA_WIDTH'($signed(rd_sh[7:0]));
         F3_H:    load_data = DATA_WIDTH'($signed(rd_sh[15:0]));
         F3_W:    load_data = DATA_WIDTH'($signed(rd_sh[31:0]));
         F3_D:    load_data = rd_sh;
         F3_BU:   load_data = DATA_WIDTH'(rd_sh[7:0]);
         F3_HU:   load_data = DATA_WIDTH'(rd_sh[15:0]);
         F3_WU:   load_data = DATA_WIDTH'(rd_sh[31:0]);
         default: load_data = '0;
      endcase
   end

   // NOTE: storage deliberately has no reset; only control state clears, so contents survive rst.
   always_ff @(posedge clk) begin
      if (accept && req_we_i && fault == FAULT_NONE) begin
         for (int b = 0; b < BYTES; b++) begin
            if (wmask[b]) mem[widx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
         end
      end
   end

   // NOTE: all state and registered outputs use non-blocking assignment so every
   // right-hand side sees the pre-edge value, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         cnt          <= '0;
         req_ready_o  <= 1'b1;
         resp_valid_o <= 1'b0;
         resp_rdata_o <= '0;
         resp_fault_o <= FAULT_NONE;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid_i) begin
                  req_ready_o  <= 1'b0;
                  resp_fault_o <= fault;
                  resp_rdata_o <= (!req_we_i && fault == FAULT_NONE) ? load_data : '0;
                  if (READ_LATENCY == 1) begin
                     state        <= S_RESP;
                     resp_valid_o <= 1'b1;
                  end else begin
                     state <= S_WAIT;
                     cnt   <= 3'(READ_LATENCY - 1);
                  end
               end
            end
            S_WAIT: begin
               if (cnt == 3'd1) begin
                  state        <= S_RESP;
                  resp_valid_o <= 1'b1;
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
            S_RESP: begin
               // Ready rises only after the handshake edge, so no accept shares that cycle.
               if (resp_ready_i) begin
                  state        <= S_IDLE;
                  resp_valid_o <= 1'b0;
                  req_ready_o  <= 1'b1;
               end
            end
            default: begin
               state        <= S_IDLE;
               req_ready_o  <= 1'b1;
               resp_valid_o <= 1'b0;
            end
         endcase
      end
   end

endmodule
